rtc_shadow_bank: RTL and testbench

- Clocked, parametrised replacement for the combinational latch steering between the RTC bus controller and the VGA time display.
- Captures bytes read from the RTC into per-field staging registers and BCD-checks each one.
- On `commit`, copies staging into a shadow bank atomically, so the display never shows a torn time or date.
- Also streams the shadow bank back out to the RTC write path through a valid/ready sequencer. This replaces the old always-on bus mux with a registered output enable.

---
 rtl/rtc_pkg.sv | 21 ++
 rtl/rtc_shadow_bank_if.sv | 35 +++
 rtl/bcd_byte_check.sv | 20 ++
 rtl/rtc_shadow_bank.sv | 179 +++++++++++++++++
 tb/tb_rtc_shadow_bank.sv | 284 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rtc_pkg.sv
// Shared definitions for the RTC shadow bank.
// Field index constants for the time/date bank, the default field width and
// the write-back sequencer state encoding.
package rtc_pkg;

  localparam int DW_DEFAULT = 8;

  localparam int F_SEC   = 0;
  localparam int F_MIN   = 1;
  localparam int F_HOUR  = 2;
  localparam int F_DAY   = 3;
  localparam int F_MONTH = 4;
  localparam int F_YEAR  = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } wb_state_t;

endpackage

// File: rtl/rtc_shadow_bank_if.sv
// Write-back stream from the shadow bank to the RTC write path.
//   wb_valid  byte on wb_idx/wb_data is valid
//   wb_ready  RTC write path accepts the current byte
//   wb_idx    field index of the byte
//   wb_data   field byte
//   bus_oe    registered drive enable for the RTC data bus
// master: shadow bank side; slave: RTC write path side.
interface rtc_shadow_bank_if #(
  parameter int DW   = 8,
  parameter int IDXW = 3
);

  logic            wb_valid;
  logic            wb_ready;
  logic [IDXW-1:0] wb_idx;
  logic [DW-1:0]   wb_data;
  logic            bus_oe;

  modport master (
    output wb_valid,
    output wb_idx,
    output wb_data,
    output bus_oe,
    input  wb_ready
  );

  modport slave (
    input  wb_valid,
    input  wb_idx,
    input  wb_data,
    input  bus_oe,
    output wb_ready
  );

endinterface

// File: rtl/bcd_byte_check.sv
// Combinational BCD validity check of a captured byte.
//   data  captured byte (DW bits, packed BCD nibbles)
//   ok    1 when every complete nibble is in 0..9
module bcd_byte_check #(
  parameter int DW = 8
) (
  input  logic [DW-1:0] data,
  output logic          ok
);

  localparam int unsigned NNIB = DW / 4;

  always_comb begin
    ok = 1'b1;
    for (int unsigned n = 0; n < NNIB; n++) begin
      if (data[n*4 +: 4] > 4'd9) ok = 1'b0;
    end
  end

endmodule

// File: rtl/rtc_shadow_bank.sv
// Clocked staging/shadow bank between the RTC bus controller and the VGA
// time display, with a valid/ready write-back sequencer to the RTC.
//   clk, reset      system clock, asynchronous active-high reset
//   cap_valid/idx/data  byte capture from the RTC read path
//   commit          copy staging -> shadow (deferred while write-back busy)
//   wb_start        stream every shadow field out through `wb`
//   wb              write-back stream (valid/ready/idx/data) and bus_oe
//   wb_busy         sequencer not idle
//   wb_done         one-cycle pulse after the last field is accepted
//   shadow_flat     shadow bank, field i at [i*DW +: DW]
//   stage_dirty     staging field written since last commit
//   cap_err         one-cycle pulse when a capture is rejected
module rtc_shadow_bank
  import rtc_pkg::*;
#(
  parameter int NFIELDS   = 6,
  parameter int DW        = DW_DEFAULT,
  parameter int IDXW      = 3,
  parameter bit BCD_CHECK = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cap_valid,
  input  logic [IDXW-1:0]       cap_idx,
  input  logic [DW-1:0]         cap_data,
  input  logic                  commit,
  input  logic                  wb_start,
  rtc_shadow_bank_if.master     wb,
  output logic                  wb_busy,
  output logic                  wb_done,
  output logic [NFIELDS*DW-1:0] shadow_flat,
  output logic [NFIELDS-1:0]    stage_dirty,
  output logic                  cap_err
);

  wb_state_t state, state_n;

  logic [DW-1:0]      stage    [NFIELDS];
  logic [DW-1:0]      stage_n  [NFIELDS];
  logic [DW-1:0]      shadow   [NFIELDS];
  logic [DW-1:0]      shadow_n [NFIELDS];
  logic [NFIELDS-1:0] dirty_n;

  logic            commit_pend, commit_pend_n, commit_apply;
  logic            bcd_ok, idx_ok, cap_ok;
  logic            handshake, last_field;
  logic [IDXW-1:0] idx_inc, idx_n;
  logic [DW-1:0]   next_field, data_n;

  // ---------------------------------------------------------------------
  // Capture qualification
  // ---------------------------------------------------------------------
  bcd_byte_check #(.DW(DW)) u_bcd (
    .data (cap_data),
    .ok   (bcd_ok)
  );

  assign idx_ok = {1'b0, cap_idx} < (IDXW+1)'(NFIELDS);
  assign cap_ok = cap_valid && idx_ok && (bcd_ok || !BCD_CHECK);

  // Commits land only in IDLE or in the DONE cycle, so the shadow stays a
  // frozen snapshot for the whole SEND phase.
  assign commit_apply = ((state == IDLE) && commit) ||
                        ((state == DONE) && (commit || commit_pend));

  always_comb begin
    if (commit_apply)  commit_pend_n = 1'b0;
    else if (commit)   commit_pend_n = 1'b1;
    else               commit_pend_n = commit_pend;
  end

  // Copying from the post-capture staging image gives the same-cycle
  // capture bypass into the shadow for free.
  always_comb begin
    stage_n  = stage;
    shadow_n = shadow;
    dirty_n  = stage_dirty;
    for (int unsigned i = 0; i < NFIELDS; i++) begin
      if (cap_ok && (cap_idx == IDXW'(i))) begin
        stage_n[i] = cap_data;
        dirty_n[i] = 1'b1;
      end
    end
    if (commit_apply) begin
      shadow_n = stage_n;
      dirty_n  = '0;
    end
  end

  for (genvar g = 0; g < NFIELDS; g++) begin : g_flat
    assign shadow_flat[g*DW +: DW] = shadow[g];
  end

  // ---------------------------------------------------------------------
  // Write-back sequencer
  // ---------------------------------------------------------------------
  assign handshake  = (state == SEND) && wb.wb_ready;
  assign last_field = (wb.wb_idx == IDXW'(NFIELDS-1));
  assign idx_inc    = wb.wb_idx + 1'b1;

  always_comb begin
    next_field = '0;
    for (int unsigned i = 0; i < NFIELDS; i++) begin
      if (idx_inc == IDXW'(i)) next_field = shadow[i];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    idx_n   = wb.wb_idx;
    data_n  = wb.wb_data;
    case (state)
      IDLE: begin
        if (wb_start) begin
          state_n = SEND;
          idx_n   = '0;
          // A commit in the start cycle is already in shadow_n, keeping the
          // first byte consistent with the rest of the stream.
          data_n  = shadow_n[0];
        end
      end
      SEND: begin
        if (handshake) begin
          if (last_field) begin
            state_n = DONE;
          end else begin
            idx_n  = idx_inc;
            data_n = next_field;
          end
        end
      end
      DONE: begin
        state_n = IDLE;
        idx_n   = '0;
      end
      default: begin
        state_n = IDLE;
        idx_n   = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stage       <= '{default: '0};
      shadow      <= '{default: '0};
      stage_dirty <= '0;
      commit_pend <= 1'b0;
      cap_err     <= 1'b0;
      wb.wb_idx   <= '0;
      wb.wb_data  <= '0;
      wb.wb_valid <= 1'b0;
      wb.bus_oe   <= 1'b0;
      wb_busy     <= 1'b0;
      wb_done     <= 1'b0;
    end else begin
      stage       <= stage_n;
      shadow      <= shadow_n;
      stage_dirty <= dirty_n;
      commit_pend <= commit_pend_n;
      cap_err     <= cap_valid && !cap_ok;
      wb.wb_idx   <= idx_n;
      wb.wb_data  <= data_n;
      wb.wb_valid <= (state_n == SEND);
      wb.bus_oe   <= (state_n == SEND);
      wb_busy     <= (state_n != IDLE);
      wb_done     <= (state_n == DONE);
    end
  end

endmodule

// File: tb/tb_rtc_shadow_bank.sv
module tb_rtc_shadow_bank;

  logic        clk = 1'b0;
  logic        reset;
  logic        cap_valid, commit, wb_start;
  logic [2:0]  cap_idx;
  logic [7:0]  cap_data;

  logic        wb_busy, wb_done, cap_err;
  logic [47:0] shadow_flat;
  logic [5:0]  stage_dirty;

  logic        nb_busy, nb_done, nb_cap_err;
  logic [47:0] nb_shadow;
  logic [5:0]  nb_dirty;

  int tests = 0;
  int fails = 0;

  typedef struct packed {
    logic [2:0] idx;
    logic [7:0] data;
  } beat_t;
  beat_t sb[$];

  logic [7:0] m_stage  [6];
  logic [7:0] m_shadow [6];

  rtc_shadow_bank_if #(.DW(8), .IDXW(3)) wbi ();
  rtc_shadow_bank_if #(.DW(8), .IDXW(3)) wbi_nb ();
  assign wbi_nb.wb_ready = wbi.wb_ready;

  rtc_shadow_bank #(.NFIELDS(6), .DW(8), .IDXW(3), .BCD_CHECK(1'b1)) dut (
    .clk(clk), .reset(reset), .cap_valid(cap_valid), .cap_idx(cap_idx),
    .cap_data(cap_data), .commit(commit), .wb_start(wb_start), .wb(wbi),
    .wb_busy(wb_busy), .wb_done(wb_done), .shadow_flat(shadow_flat),
    .stage_dirty(stage_dirty), .cap_err(cap_err)
  );

  rtc_shadow_bank #(.NFIELDS(6), .DW(8), .IDXW(3), .BCD_CHECK(1'b0)) dut_nb (
    .clk(clk), .reset(reset), .cap_valid(cap_valid), .cap_idx(cap_idx),
    .cap_data(cap_data), .commit(commit), .wb_start(wb_start), .wb(wbi_nb),
    .wb_busy(nb_busy), .wb_done(nb_done), .shadow_flat(nb_shadow),
    .stage_dirty(nb_dirty), .cap_err(nb_cap_err)
  );

  always #5 clk = ~clk;

  function automatic logic [47:0] m_flat();
    logic [47:0] r;
    for (int i = 0; i < 6; i++) r[i*8 +: 8] = m_shadow[i];
    return r;
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic model_clear();
    for (int i = 0; i < 6; i++) begin
      m_stage[i]  = 8'h00;
      m_shadow[i] = 8'h00;
    end
  endtask

  task automatic model_commit();
    for (int i = 0; i < 6; i++) m_shadow[i] = m_stage[i];
  endtask

  task automatic push_stream();
    for (int i = 0; i < 6; i++) sb.push_back('{idx: 3'(i), data: m_shadow[i]});
  endtask

  task automatic test_reset();
    reset = 1'b1;
    cap_valid = 1'b0; cap_idx = '0; cap_data = '0;
    commit = 1'b0; wb_start = 1'b0; wbi.wb_ready = 1'b0;
    model_clear();
    tick(); tick();
    tests++; if (shadow_flat !== 48'h0) begin fails++; $display("FAIL reset_shadow got=%h exp=%h", shadow_flat, 48'h0); end
    tests++; if (stage_dirty !== 6'h0) begin fails++; $display("FAIL reset_dirty got=%b exp=%b", stage_dirty, 6'h0); end
    tests++; if (wb_busy !== 1'b0) begin fails++; $display("FAIL reset_busy got=%b exp=0", wb_busy); end
    tests++; if (wbi.wb_valid !== 1'b0 || wbi.bus_oe !== 1'b0) begin fails++; $display("FAIL reset_valid_oe got=%b%b exp=00", wbi.wb_valid, wbi.bus_oe); end
    tests++; if (wb_done !== 1'b0 || cap_err !== 1'b0) begin fails++; $display("FAIL reset_pulses got=%b%b exp=00", wb_done, cap_err); end
    reset = 1'b0;
    tick();
    tests++; if (wb_busy !== 1'b0 || wbi.wb_idx !== 3'd0) begin fails++; $display("FAIL idle_after_reset busy=%b idx=%0d exp 0/0", wb_busy, wbi.wb_idx); end
  endtask

  task automatic test_capture_commit();
    cap_valid = 1'b1; cap_idx = 3'd0; cap_data = 8'h59;
    m_stage[0] = 8'h59;
    tick();
    cap_valid = 1'b0;
    tests++; if (stage_dirty !== 6'b000001) begin fails++; $display("FAIL cap_dirty got=%b exp=%b", stage_dirty, 6'b000001); end
    tests++; if (shadow_flat !== 48'h0) begin fails++; $display("FAIL cap_no_shadow got=%h exp=%h", shadow_flat, 48'h0); end
    commit = 1'b1;
    tick();
    commit = 1'b0;
    model_commit();
    tests++; if (shadow_flat[7:0] !== 8'h59) begin fails++; $display("FAIL commit_sec got=%h exp=59", shadow_flat[7:0]); end
    tests++; if (shadow_flat !== m_flat()) begin fails++; $display("FAIL commit_flat got=%h exp=%h", shadow_flat, m_flat()); end
    tests++; if (stage_dirty !== 6'h0) begin fails++; $display("FAIL commit_dirty got=%b exp=0", stage_dirty); end
  endtask

  task automatic test_cap_err();
    logic [47:0] nb_exp;
    cap_valid = 1'b1; cap_idx = 3'd2; cap_data = 8'h1A;
    tick();
    tests++; if (cap_err !== 1'b1) begin fails++; $display("FAIL bcd_err got=%b exp=1", cap_err); end
    tests++; if (stage_dirty !== 6'h0) begin fails++; $display("FAIL bcd_dirty got=%b exp=0", stage_dirty); end
    tests++; if (nb_cap_err !== 1'b0 || nb_dirty !== 6'b000100) begin fails++; $display("FAIL nobcd_accept err=%b dirty=%b exp 0/000100", nb_cap_err, nb_dirty); end
    cap_idx = 3'd7; cap_data = 8'h12;
    tick();
    tests++; if (cap_err !== 1'b1 || nb_cap_err !== 1'b1) begin fails++; $display("FAIL range_err got=%b%b exp=11", cap_err, nb_cap_err); end
    tests++; if (stage_dirty !== 6'h0) begin fails++; $display("FAIL range_dirty got=%b exp=0", stage_dirty); end
    cap_valid = 1'b0;
    tick();
    tests++; if (cap_err !== 1'b0) begin fails++; $display("FAIL err_pulse got=%b exp=0", cap_err); end
    commit = 1'b1;
    tick();
    commit = 1'b0;
    model_commit();
    nb_exp = m_flat();
    nb_exp[23:16] = 8'h1A;
    tests++; if (shadow_flat !== m_flat()) begin fails++; $display("FAIL err_stage_kept got=%h exp=%h", shadow_flat, m_flat()); end
    tests++; if (nb_shadow !== nb_exp) begin fails++; $display("FAIL nobcd_shadow got=%h exp=%h", nb_shadow, nb_exp); end
  endtask

  task automatic test_bypass();
    cap_valid = 1'b1; cap_idx = 3'd1; cap_data = 8'h30; commit = 1'b1;
    m_stage[1] = 8'h30;
    tick();
    cap_valid = 1'b0; commit = 1'b0;
    model_commit();
    tests++; if (shadow_flat[15:8] !== 8'h30) begin fails++; $display("FAIL bypass_min got=%h exp=30", shadow_flat[15:8]); end
    tests++; if (stage_dirty[1] !== 1'b0) begin fails++; $display("FAIL bypass_dirty got=%b exp=0", stage_dirty[1]); end
    tests++; if (shadow_flat !== m_flat()) begin fails++; $display("FAIL bypass_flat got=%h exp=%h", shadow_flat, m_flat()); end
  endtask

  task automatic load_bank();
    logic [7:0] vals [6];
    vals = '{8'h58, 8'h59, 8'h23, 8'h31, 8'h12, 8'h24};
    for (int i = 0; i < 6; i++) begin
      cap_valid = 1'b1; cap_idx = 3'(i); cap_data = vals[i];
      m_stage[i] = vals[i];
      tick();
    end
    cap_valid = 1'b0; commit = 1'b1;
    tick();
    commit = 1'b0;
    model_commit();
  endtask

  task automatic test_writeback();
    beat_t b;
    load_bank();
    tests++; if (shadow_flat !== 48'h24_12_31_23_59_58) begin fails++; $display("FAIL wb_load got=%h exp=%h", shadow_flat, 48'h24_12_31_23_59_58); end
    push_stream();
    wbi.wb_ready = 1'b1; wb_start = 1'b1;
    tick();
    wb_start = 1'b0;
    for (int c = 1; c <= 9; c++) begin
      tests++; if (wbi.bus_oe !== (c <= 6)) begin fails++; $display("FAIL wb_oe c=%0d got=%b exp=%b", c, wbi.bus_oe, (c <= 6)); end
      tests++; if (wb_done !== (c == 7)) begin fails++; $display("FAIL wb_done c=%0d got=%b exp=%b", c, wb_done, (c == 7)); end
      tests++; if (wb_busy !== (c <= 7)) begin fails++; $display("FAIL wb_busy c=%0d got=%b exp=%b", c, wb_busy, (c <= 7)); end
      if (wbi.wb_valid === 1'b1 && wbi.wb_ready === 1'b1) begin
        tests++;
        if (sb.size() == 0) begin
          fails++; $display("FAIL wb_extra c=%0d idx=%0d data=%h exp none", c, wbi.wb_idx, wbi.wb_data);
        end else begin
          b = sb.pop_front();
          if (wbi.wb_idx !== b.idx || wbi.wb_data !== b.data) begin
            fails++; $display("FAIL wb_beat c=%0d got=%0d/%h exp=%0d/%h", c, wbi.wb_idx, wbi.wb_data, b.idx, b.data);
          end
        end
      end
      tick();
    end
    tests++; if (sb.size() != 0) begin fails++; $display("FAIL wb_missing got=%0d left exp=0", sb.size()); sb.delete(); end
    tests++; if (wbi.wb_idx !== 3'd0) begin fails++; $display("FAIL wb_idx_wrap got=%0d exp=0", wbi.wb_idx); end
  endtask

  task automatic test_stall_commit();
    beat_t b;
    bit done_seen = 1'b0;
    int cyc = 0;
    push_stream();
    wbi.wb_ready = 1'b0; wb_start = 1'b1;
    tick();
    wb_start = 1'b0;
    for (int k = 0; k < 60 && !done_seen; k++) begin
      cyc++;
      cap_valid = 1'b0; commit = 1'b0; wb_start = 1'b0;
      tests++; if (shadow_flat[7:0] !== 8'h58) begin fails++; $display("FAIL stall_shadow_frozen cyc=%0d got=%h exp=58", cyc, shadow_flat[7:0]); end
      if (wb_done === 1'b1) begin
        done_seen = 1'b1;
        wbi.wb_ready = 1'b0;
      end else begin
        wbi.wb_ready = cyc[0];
        if (cyc == 2) begin
          cap_valid = 1'b1; cap_idx = 3'd0; cap_data = 8'h00; commit = 1'b1; wb_start = 1'b1;
          m_stage[0] = 8'h00;
        end
        if (wbi.wb_valid === 1'b1 && wbi.wb_ready === 1'b1) begin
          tests++;
          if (sb.size() == 0) begin
            fails++; $display("FAIL stall_extra idx=%0d data=%h exp none", wbi.wb_idx, wbi.wb_data);
          end else begin
            b = sb.pop_front();
            if (wbi.wb_idx !== b.idx || wbi.wb_data !== b.data) begin
              fails++; $display("FAIL stall_beat got=%0d/%h exp=%0d/%h", wbi.wb_idx, wbi.wb_data, b.idx, b.data);
            end
          end
        end
      end
      tick();
    end
    cap_valid = 1'b0; commit = 1'b0; wb_start = 1'b0;
    tests++; if (!done_seen) begin fails++; $display("FAIL stall_timeout got=no wb_done exp=wb_done within 60 cycles"); end
    model_commit();
    tests++; if (shadow_flat !== m_flat()) begin fails++; $display("FAIL stall_commit_applied got=%h exp=%h", shadow_flat, m_flat()); end
    tests++; if (stage_dirty !== 6'h0) begin fails++; $display("FAIL stall_dirty got=%b exp=0", stage_dirty); end
    tests++; if (sb.size() != 0) begin fails++; $display("FAIL stall_missing got=%0d left exp=0", sb.size()); sb.delete(); end
    tick();
    tests++; if (wb_busy !== 1'b0 || wbi.wb_valid !== 1'b0) begin fails++; $display("FAIL start_not_queued busy=%b valid=%b exp 0/0", wb_busy, wbi.wb_valid); end
  endtask

  task automatic test_reset_mid_send();
    beat_t b;
    bit hit = 1'b0;
    push_stream();
    wbi.wb_ready = 1'b1; wb_start = 1'b1;
    tick();
    wb_start = 1'b0;
    for (int k = 0; k < 20 && !hit; k++) begin
      if (wbi.wb_valid === 1'b1 && wbi.wb_idx === 3'd3) begin
        hit = 1'b1;
      end else begin
        if (wbi.wb_valid === 1'b1 && sb.size() != 0) begin
          b = sb.pop_front();
          tests++;
          if (wbi.wb_idx !== b.idx || wbi.wb_data !== b.data) begin
            fails++; $display("FAIL rst_pre_beat got=%0d/%h exp=%0d/%h", wbi.wb_idx, wbi.wb_data, b.idx, b.data);
          end
        end
        tick();
      end
    end
    tests++; if (!hit) begin fails++; $display("FAIL rst_reach_idx3 got=not reached exp=idx 3 within 20 cycles"); end
    #2 reset = 1'b1;
    #1;
    sb.delete();
    model_clear();
    tests++; if (wbi.wb_valid !== 1'b0 || wbi.bus_oe !== 1'b0 || wb_busy !== 1'b0) begin fails++; $display("FAIL rst_async_drop got=%b%b%b exp=000", wbi.wb_valid, wbi.bus_oe, wb_busy); end
    tests++; if (shadow_flat !== m_flat()) begin fails++; $display("FAIL rst_shadow got=%h exp=%h", shadow_flat, m_flat()); end
    for (int k = 0; k < 3; k++) begin
      tick();
      tests++; if (wb_done !== 1'b0) begin fails++; $display("FAIL rst_no_done got=%b exp=0", wb_done); end
    end
    reset = 1'b0;
    tick();
    tests++; if (wb_done !== 1'b0 || wb_busy !== 1'b0 || wbi.wb_idx !== 3'd0) begin fails++; $display("FAIL rst_idle done=%b busy=%b idx=%0d exp 0/0/0", wb_done, wb_busy, wbi.wb_idx); end
  endtask

  initial begin
    test_reset();
    test_capture_commit();
    test_cap_err();
    test_bypass();
    test_writeback();
    test_stall_commit();
    test_reset_mid_send();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish before 200000");
    $fatal(1);
  end

endmodule
